// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read ports, ALU write port and load issue/done ports.
interface reg_file_sb_if #(
  parameter int W = 8,
  parameter int D = 4
);
  logic              branch_en;
  logic [D-1:0]      r_addr_a;
  logic [D-1:0]      r_addr_b;
  logic [W-1:0]      data_out_a;
  logic [W-1:0]      data_out_b;
  logic              write_en;
  logic [D-1:0]      w_addr;
  logic [W-1:0]      data_in;
  logic              ld_issue;
  logic [D-1:0]      ld_addr;
  logic              ld_done;
  logic [D-1:0]      ld_dst;
  logic [W-1:0]      ld_data;
  logic              stall;
  logic              hazard;
  logic [2**D-1:0]   busy_vec;

  modport master (
    output branch_en, r_addr_a, r_addr_b, write_en, w_addr, data_in,
           ld_issue, ld_addr, ld_done, ld_dst, ld_data,
    input  data_out_a, data_out_b, stall, hazard, busy_vec
  );

  modport slave (
    input  branch_en, r_addr_a, r_addr_b, write_en, w_addr, data_in,
           ld_issue, ld_addr, ld_done, ld_dst, ld_data,
    output data_out_a, data_out_b, stall, hazard, busy_vec
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with a load scoreboard: per-register pending bits, same-cycle
// forwarding from the load-completion and ALU write ports, stall and hazard flags.
module reg_file_sb #(
  parameter int W    = 8,
  parameter int D    = 4,
  parameter int BR_A = 7,
  parameter int BR_B = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  reg_file_sb_if.slave bus
);
  localparam int N = 1 << D;

  logic [N-1:0][W-1:0] regs;
  logic [N-1:0]        busy;
  logic                hazard_q;

  // A busy target is only writable when its load completes the same cycle,
  // and then the load data wins anyway.
  logic wr_done, iss_done, wr_bad, wr_ok, iss_bad, iss_ok;
  assign wr_done  = bus.ld_done && (bus.ld_dst == bus.w_addr);
  assign iss_done = bus.ld_done && (bus.ld_dst == bus.ld_addr);
  assign wr_bad   = bus.write_en && busy[bus.w_addr] && !wr_done;
  assign wr_ok    = bus.write_en && !wr_bad;
  assign iss_bad  = bus.ld_issue && busy[bus.ld_addr] && !iss_done;
  assign iss_ok   = bus.ld_issue && !iss_bad;

  // Storage, pending bits and hazard pulse; later assignments take priority
  // (load data over ALU data, re-issue over completion).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      regs     <= '0;
      busy     <= '0;
      hazard_q <= 1'b0;
    end else begin
      if (wr_ok)        regs[bus.w_addr] <= bus.data_in;
      if (bus.ld_done)  regs[bus.ld_dst] <= bus.ld_data;
      if (bus.ld_done)  busy[bus.ld_dst] <= 1'b0;
      if (iss_ok)       busy[bus.ld_addr] <= 1'b1;
      hazard_q <= wr_bad | iss_bad;
    end
  end

  logic [1:0][D-1:0] raddr;
  logic [1:0][D-1:0] brsel;
  assign raddr[0] = bus.r_addr_a;
  assign raddr[1] = bus.r_addr_b;
  assign brsel[0] = D'(BR_A);
  assign brsel[1] = D'(BR_B);

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [D-1:0] eff;
    logic [W-1:0] val;
    logic         hit_ld;
    logic         stl;

    assign eff    = bus.branch_en ? brsel[p] : raddr[p];
    assign hit_ld = bus.ld_done && (bus.ld_dst == eff);
    // A rejected ALU write is not forwarded: the reader stalls on stale data.
    assign stl    = busy[eff] && !hit_ld;

    // Read mux with same-cycle forwarding, load completion first.
    always_comb begin
      val = regs[eff];
      if (hit_ld)                          val = bus.ld_data;
      else if (wr_ok && bus.w_addr == eff) val = bus.data_in;
    end
  end

  assign bus.data_out_a = g_rd[0].val;
  assign bus.data_out_b = g_rd[1].val;
  assign bus.stall      = g_rd[0].stl | g_rd[1].stl;
  assign bus.hazard     = hazard_q;
  assign bus.busy_vec   = busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: stimulus pushes expected values tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_reg_file_sb;
  localparam int W = 8;
  localparam int D = 4;

  typedef enum int {F_A, F_B, F_STALL, F_HAZ, F_BUSY} field_e;
  typedef struct {
    string  name;
    int     cyc;
    field_e fld;
    int     val;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q[$];

  reg_file_sb_if #(.W(W), .D(D)) bus ();

  reg_file_sb #(.W(W), .D(D), .BR_A(7), .BR_B(0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int actual(field_e f);
    case (f)
      F_A:     return int'(bus.data_out_a);
      F_B:     return int'(bus.data_out_b);
      F_STALL: return int'(bus.stall);
      F_HAZ:   return int'(bus.hazard);
      default: return int'(bus.busy_vec);
    endcase
  endfunction

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc == cyc) begin
        n_vec++;
        if (actual(q[i].fld) != q[i].val) begin
          n_bad++;
          $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                   q[i].name, actual(q[i].fld), q[i].val, cyc);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_at(string name, field_e f, int val, int dly = 0);
    exp_t e;
    e.name = name; e.cyc = cyc + dly; e.fld = f; e.val = val;
    q.push_back(e);
  endtask

  task automatic idle();
    bus.branch_en = 0; bus.r_addr_a = 0; bus.r_addr_b = 0;
    bus.write_en = 0; bus.w_addr = 0; bus.data_in = 0;
    bus.ld_issue = 0; bus.ld_addr = 0;
    bus.ld_done = 0; bus.ld_dst = 0; bus.ld_data = 0;
  endtask

  // Advance to just after the next rising edge and clear the inputs.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int a, input int d);
    bus.write_en = 1; bus.w_addr = D'(a); bus.data_in = W'(d);
  endtask

  task automatic issue(input int a);
    bus.ld_issue = 1; bus.ld_addr = D'(a);
  endtask

  task automatic done(input int a, input int d);
    bus.ld_done = 1; bus.ld_dst = D'(a); bus.ld_data = W'(d);
  endtask

  task automatic rd(input int a, input int b);
    bus.r_addr_a = D'(a); bus.r_addr_b = D'(b);
  endtask

  initial begin
    idle();
    reset_n = 0;
    step(); step();
    reset_n = 1;

    // Reset state for every address.
    expect_at("rst_busy", F_BUSY, 0);
    expect_at("rst_haz", F_HAZ, 0);
    for (int i = 0; i < 16; i++) begin
      rd(i, 15 - i);
      expect_at($sformatf("rst_a%0d", i), F_A, 0);
      expect_at($sformatf("rst_b%0d", 15 - i), F_B, 0);
      expect_at($sformatf("rst_stall%0d", i), F_STALL, 0);
      step();
    end

    // ALU write forwarded in the write cycle, then from storage.
    wr(3, 8'h5A); rd(3, 0);
    expect_at("fwd_wr", F_A, 8'h5A);
    step();
    rd(3, 0);
    expect_at("stored_wr", F_A, 8'h5A);
    step();

    // Load issue, stall on pending read, completion forwarded.
    issue(5);
    step();
    rd(0, 5);
    expect_at("ld_stall", F_STALL, 1);
    expect_at("ld_busy", F_BUSY, 16'h0020);
    expect_at("ld_stale", F_B, 0);
    step();
    done(5, 8'hC3); rd(0, 5);
    expect_at("ld_done_stall", F_STALL, 0);
    expect_at("ld_done_fwd", F_B, 8'hC3);
    expect_at("ld_done_busy_hold", F_BUSY, 16'h0020);
    step();
    rd(0, 5);
    expect_at("ld_cleared", F_BUSY, 0);
    expect_at("ld_stored", F_B, 8'hC3);
    step();

    // Write to busy register: rejected, one-cycle hazard.
    issue(5);
    step();
    wr(5, 8'h11);
    expect_at("haz_pre", F_HAZ, 0);
    expect_at("haz_pulse", F_HAZ, 1, 1);
    step();
    rd(5, 0);
    expect_at("haz_unchanged", F_A, 8'hC3);
    expect_at("haz_stall", F_STALL, 1);
    step();
    expect_at("haz_drop", F_HAZ, 0);
    // Back-to-back offenses: two writes then a re-issue to a busy register.
    wr(5, 8'h22);
    step();
    wr(5, 8'h33);
    expect_at("haz_b2b1", F_HAZ, 1);
    step();
    issue(5);
    expect_at("haz_b2b2", F_HAZ, 1);
    step();
    expect_at("haz_b2b3", F_HAZ, 1);
    step();
    expect_at("haz_b2b_end", F_HAZ, 0);
    // Complete and re-issue in one cycle: data stored, bit stays set.
    done(5, 8'h77); issue(5);
    step();
    rd(5, 0);
    expect_at("reissue_busy", F_BUSY, 16'h0020);
    expect_at("reissue_data", F_A, 8'h77);
    expect_at("reissue_haz", F_HAZ, 0);
    step();
    done(5, 8'h78);
    step();
    // Completion to a non-busy register is a plain write.
    done(9, 8'h99);
    step();
    rd(9, 5);
    expect_at("plain_ld_a", F_A, 8'h99);
    expect_at("plain_ld_b", F_B, 8'h78);
    expect_at("plain_ld_haz", F_HAZ, 0);
    expect_at("plain_ld_busy", F_BUSY, 0);
    step();

    // Load completion beats ALU write to the same register.
    wr(2, 8'h01); done(2, 8'h02); rd(2, 0);
    expect_at("prio_fwd", F_A, 8'h02);
    step();
    rd(2, 0);
    expect_at("prio_stored", F_A, 8'h02);
    step();

    // Branch compare registers override read addresses.
    wr(7, 8'h40);
    step();
    wr(0, 8'h09);
    step();
    bus.branch_en = 1; rd(1, 2);
    expect_at("br_a", F_A, 8'h40);
    expect_at("br_b", F_B, 8'h09);
    step();
    rd(1, 2);
    expect_at("nobr_a", F_A, 0);
    expect_at("nobr_b", F_B, 8'h02);
    step();

    // Reset mid-operation discards pending loads and offending inputs.
    issue(4);
    step();
    issue(6);
    step();
    reset_n = 0;
    wr(4, 8'hEE); issue(8);
    expect_at("pre_rst_busy", F_BUSY, 16'h0050, 0);
    step();
    reset_n = 1;
    rd(3, 7);
    expect_at("mid_rst_busy", F_BUSY, 0);
    expect_at("mid_rst_haz", F_HAZ, 0);
    expect_at("mid_rst_stall", F_STALL, 0);
    expect_at("mid_rst_a", F_A, 0);
    expect_at("mid_rst_b", F_B, 0);
    step();
    done(4, 8'h44);
    expect_at("late_done_haz", F_HAZ, 0, 1);
    step();
    rd(4, 0);
    expect_at("late_done_data", F_A, 8'h44);
    expect_at("late_done_busy", F_BUSY, 0);
    step();

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && q.size() > 0; k++) step();
    if (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter W, default 8, meaning data path width in bits.
REQ-002 SHALL have parameter D, default 4, meaning address width; register count is 2**D.
REQ-003 SHALL have parameter BR_A, default 7, meaning register index driven on port A while branch_en=1.
REQ-004 SHALL have parameter BR_B, default 0, meaning register index driven on port B while branch_en=1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port branch_en, input, 1 bit: selects the fixed compare registers on both read ports.
REQ-008 SHALL have ports r_addr_a and r_addr_b, input, D bits each: read addresses.
REQ-009 SHALL have ports data_out_a and data_out_b, output, W bits each: combinational read data.
REQ-010 SHALL have ports write_en (input, 1), w_addr (input, D), data_in (input, W): ALU write port.
REQ-011 SHALL have ports ld_issue (input, 1) and ld_addr (input, D): mark a load destination pending.
REQ-012 SHALL have ports ld_done (input, 1), ld_dst (input, D), ld_data (input, W): load completion write port.
REQ-013 SHALL have port stall, output, 1 bit: a read port addresses a pending register.
REQ-014 SHALL have port hazard, output, 1 bit: registered one-cycle pulse flagging a rejected write or issue.
REQ-015 SHALL have port busy_vec, output, 2**D bits: current pending bit per register.

Function
REQ-016 SHALL resolve effective read indices as BR_A/BR_B when branch_en=1, else r_addr_a/r_addr_b.
REQ-017 SHALL forward, same cycle, ld_data when ld_done=1 and ld_dst equals the effective index; else data_in when write_en=1 and w_addr equals it; else the stored value.
REQ-018 SHALL give ld_done priority over write_en when both target the same register in one cycle; only ld_data is stored.
REQ-019 SHALL, on ld_done, store ld_data into ld_dst and clear busy_vec[ld_dst] at the next edge.
REQ-020 SHALL, on ld_issue with busy_vec[ld_addr]=0, set busy_vec[ld_addr] at the next edge.
REQ-021 SHALL treat ld_issue and ld_done to the same address in one cycle as complete-then-reissue: data stored, busy bit ends set.
REQ-022 SHALL ignore ld_issue to an already-busy address not completing that cycle, and assert hazard the following cycle.
REQ-023 SHALL ignore write_en to a busy register not completing that cycle, and assert hazard the following cycle.
REQ-024 SHALL hold hazard high exactly one cycle per offending cycle; back-to-back offenses keep it high continuously.
REQ-025 SHALL drive stall=1 combinationally when either effective read index is busy and not completed by ld_done that cycle.
REQ-026 SHALL still drive data_out_a/b while stall=1, with the stored (stale) value.
REQ-027 SHALL allow any number of simultaneously pending registers, up to 2**D.
REQ-028 SHALL accept ld_done to a non-busy register as a plain write with no hazard.
REQ-029 SHALL have zero write-to-read latency for the stored value: a write at edge N is visible from the cycle after edge N, and via forwarding in the write cycle itself.

Reset
REQ-030 SHALL, when reset_n=0 at a rising edge, clear all registers to 0, busy_vec to 0 and hazard to 0, ignoring all write/issue/done inputs that cycle.
REQ-031 SHALL, after reset, present data_out_a=0, data_out_b=0 and stall=0 for every address.
REQ-032 SHALL discard pending loads on reset mid-operation; a later ld_done acts per REQ-028.

Verification
REQ-033 SHALL pass: reset, write_en w_addr=3 data_in=0x5A, same-cycle read r_addr_a=3 -> data_out_a=0x5A (forwarded), then 0x5A from storage.
REQ-034 SHALL pass: ld_issue ld_addr=5, next cycle read r_addr_b=5 -> stall=1, busy_vec[5]=1; ld_done ld_dst=5 ld_data=0xC3 -> stall=0, data_out_b=0xC3 same cycle.
REQ-035 SHALL pass: with register 5 busy, write_en w_addr=5 data_in=0x11 -> register unchanged, hazard=1 for exactly one cycle.
REQ-036 SHALL pass: write_en and ld_done both to address 2 with 0x01 and 0x02 -> register 2 holds 0x02.
REQ-037 SHALL pass: registers 7=0x40 and 0=0x09, branch_en=1 with r_addr_a=1, r_addr_b=2 -> data_out_a=0x40, data_out_b=0x09.
REQ-038 SHALL pass: busy_vec nonzero, reset_n=0 one cycle -> all registers 0, busy_vec=0, hazard=0, stall=0.
